ps2_receiver: RTL and testbench
===============================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive clk cycles a synchronized ps2_clk level must hold before the filtered clock changes.
REQ-002 SHALL have parameter TIMEOUT, default 50000: clk cycles without a filtered falling edge, mid-frame, before the frame is aborted.
REQ-003 SHALL use one clock and a synchronous active-high reset: clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have reset  input  1  synchronous active-high reset.
REQ-005 SHALL have ps2_clk  input  1  raw PS/2 clock line, asynchronous, idle high.
REQ-006 SHALL have ps2_data  input  1  raw PS/2 data line, asynchronous, idle high.
REQ-007 SHALL have rx_data  output  8  last correctly received byte; drives the keyboard buffer wr_data.
REQ-008 SHALL have rx_valid  output  1  one-cycle pulse, rx_data newly valid; drives the buffer we.
REQ-009 SHALL have err_parity  output  1  one-cycle pulse, frame dropped for bad parity.
REQ-010 SHALL have err_frame  output  1  one-cycle pulse, frame dropped for bad stop bit or timeout.
REQ-011 SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-013 SHALL filter synced ps2_clk: the filtered level changes only after the new level is held for FILTER_LEN consecutive cycles; shorter glitches are ignored.
REQ-014 SHALL define a falling edge as a cycle where filtered clock goes 1->0; all data sampling uses synced ps2_data in that cycle.
REQ-015 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on an edge with data=0 (start bit) -> DATA, bit counter=0; on an edge with data=1 -> stay IDLE, no error.
REQ-017 DATA: each edge shifts data in LSB-first into an 8-bit shift register; after the 8th bit -> PARITY.
REQ-018 PARITY: on an edge, store the parity bit -> STOP.
REQ-019 STOP: on an edge, always -> IDLE.
REQ-020 At the STOP edge: stop=1 and odd parity correct (data bits plus parity have an odd count of ones) -> rx_data <= shift register, rx_valid=1 the next cycle.
REQ-021 At the STOP edge: stop=1 and parity wrong -> err_parity=1 the next cycle; rx_data unchanged; no rx_valid.
REQ-022 At the STOP edge: stop=0 -> err_frame=1 the next cycle regardless of parity; no rx_valid, no err_parity.
REQ-023 SHALL keep rx_data holding its value between frames; it changes only together with rx_valid.
REQ-024 SHALL keep a timeout counter that clears on every falling edge and in IDLE; in DATA/PARITY/STOP, reaching TIMEOUT-1 -> IDLE with err_frame=1 for one cycle.
REQ-025 SHALL assert rx_valid, err_parity and err_frame for exactly one cycle each, mutually exclusive, never back-to-back for one frame.
REQ-026 SHALL accept a new start bit on the first falling edge after returning to IDLE; there is no dead time.
REQ-027 Total latency: rx_valid SHALL assert 2 (sync) + FILTER_LEN + 1 clk cycles after the raw stop-bit falling edge of ps2_clk, within one cycle.

Reset
REQ-028 Reset SHALL force state IDLE, shift register, bit and timeout counters, rx_data, rx_valid, err_parity, err_frame and busy to 0, and sync/filter registers to 1 (idle bus).
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no pulse output; the next frame after reset deasserts SHALL be received normally.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1 -> rx_valid one cycle, rx_data=0x1C, no error pulse.
REQ-031 Frames 0xF0 (parity 1) then 0x1C back-to-back -> two rx_valid pulses with rx_data 0xF0 then 0x1C.
REQ-032 Frame 0x1C with parity 1 -> err_parity one cycle, rx_valid never high, rx_data keeps its previous value.
REQ-033 Frame 0x1C with stop 0 -> err_frame one cycle, no rx_valid.
REQ-034 Start bit + 4 data bits, then idle for TIMEOUT cycles -> err_frame once, busy=0; a following 0xF0 frame is received correctly.
REQ-035 ps2_clk low glitches of FILTER_LEN-1 cycles injected mid-bit during frame 0x5A -> rx_data=0x5A, no error; reset mid-frame -> no pulses, and the next frame is received.

Source files
------------

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module : ps2_receiver
// PS/2 device-to-host frame receiver: sync, glitch filter, odd-parity check.
// Rev    : 1.0
// ============================================================================
module ps2_receiver #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       err_parity,
   output logic       err_frame,
   output logic       busy
);

   localparam int c_FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_FW-1:0] c_FILT_MAX = c_FW'(FILTER_LEN - 1);
   localparam logic [c_TW-1:0] c_TO_MAX   = c_TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic            r_clk_filt, r_clk_filt_d;
   logic [c_FW-1:0] r_filt_cnt;
   logic            w_fall;

   state_t          r_state, w_state_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic [2:0]      r_bit_cnt, w_bit_nxt;
   logic            r_par, w_par_nxt;
   logic [c_TW-1:0] r_to_cnt, w_to_nxt;
   logic [7:0]      w_rx_data_nxt;
   logic            w_valid_nxt, w_errp_nxt, w_errf_nxt;

   // Synchronizers and clock filter; all reset to the idle-bus level.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_s1     <= 1'b1;
         r_clk_s2     <= 1'b1;
         r_dat_s1     <= 1'b1;
         r_dat_s2     <= 1'b1;
         r_clk_filt   <= 1'b1;
         r_clk_filt_d <= 1'b1;
         r_filt_cnt   <= '0;
      end else begin
         r_clk_s1     <= ps2_clk;
         r_clk_s2     <= r_clk_s1;
         r_dat_s1     <= ps2_data;
         r_dat_s2     <= r_dat_s1;
         r_clk_filt_d <= r_clk_filt;
         if (r_clk_s2 != r_clk_filt) begin
            if (r_filt_cnt == c_FILT_MAX) begin
               r_clk_filt <= r_clk_s2;
               r_filt_cnt <= '0;
            end else begin
               r_filt_cnt <= r_filt_cnt + c_FW'(1);
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   assign w_fall = r_clk_filt_d & ~r_clk_filt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_par      <= 1'b0;
         r_to_cnt   <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_par      <= w_par_nxt;
         r_to_cnt   <= w_to_nxt;
         rx_data    <= w_rx_data_nxt;
         rx_valid   <= w_valid_nxt;
         err_parity <= w_errp_nxt;
         err_frame  <= w_errf_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_nxt     = r_bit_cnt;
      w_par_nxt     = r_par;
      w_to_nxt      = '0;
      w_rx_data_nxt = rx_data;
      w_valid_nxt   = 1'b0;
      w_errp_nxt    = 1'b0;
      w_errf_nxt    = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_fall && !r_dat_s2) begin
               w_state_nxt = DATA;
               w_bit_nxt   = '0;
            end
         end
         DATA: begin
            if (w_fall) begin
               w_shift_nxt = {r_dat_s2, r_shift[7:1]};
               w_bit_nxt   = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt = PARITY;
               end
            end
         end
         PARITY: begin
            if (w_fall) begin
               w_par_nxt   = r_dat_s2;
               w_state_nxt = STOP;
            end
         end
         STOP: begin
            if (w_fall) begin
               w_state_nxt = IDLE;
               // A bad stop bit masks any parity result.
               if (!r_dat_s2) begin
                  w_errf_nxt = 1'b1;
               end else if (^{r_shift, r_par}) begin
                  w_rx_data_nxt = r_shift;
                  w_valid_nxt   = 1'b1;
               end else begin
                  w_errp_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (r_state != IDLE && !w_fall) begin
         if (r_to_cnt == c_TO_MAX) begin
            w_state_nxt = IDLE;
            w_errf_nxt  = 1'b1;
         end else begin
            w_to_nxt = r_to_cnt + c_TW'(1);
         end
      end
   end

   assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_receiver
// Scoreboard bench for ps2_receiver: frames, errors, timeout, glitches, reset.
// Rev    : 1.0
// ============================================================================
module tb_ps2_receiver;

   localparam int FILTER_LEN = 4;
   localparam int TIMEOUT    = 300;
   localparam int HALF       = 20;
   localparam int LATENCY    = 2 + FILTER_LEN + 1;

   localparam logic [1:0] c_EV_VALID = 2'd0;
   localparam logic [1:0] c_EV_PAR   = 2'd1;
   localparam logic [1:0] c_EV_FRAME = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       err_parity;
   logic       err_frame;
   logic       busy;

   ev_t exp_q[$];
   ev_t mon_got;
   ev_t mon_want;
   int  checks = 0;
   int  failures = 0;
   int  lat = -1;

   always #5 clk = ~clk;

   ps2_receiver #(
      .FILTER_LEN(FILTER_LEN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .err_parity(err_parity),
      .err_frame (err_frame),
      .busy      (busy)
   );

   // Every output pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rx_valid || err_parity || err_frame) begin
         checks++;
         if (!({rx_valid, err_parity, err_frame} inside {3'b100, 3'b010, 3'b001})) begin
            failures++;
            $display("FAIL pulse_exclusive: got valid/par/frame=%b required one-hot",
                     {rx_valid, err_parity, err_frame});
         end
         mon_got.kind = rx_valid ? c_EV_VALID : (err_parity ? c_EV_PAR : c_EV_FRAME);
         mon_got.data = rx_valid ? rx_data : 8'h00;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: got kind=%0d data=%h required no pulse",
                     mon_got.kind, mon_got.data);
         end else begin
            mon_want = exp_q.pop_front();
            if (mon_got !== mon_want) begin
               failures++;
               $display("FAIL scoreboard: got kind=%0d data=%h required kind=%0d data=%h",
                        mon_got.kind, mon_got.data, mon_want.kind, mon_want.data);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [1:0] kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Drives nbits of a frame; glitch adds a FILTER_LEN-1 cycle low pulse mid high phase.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int nbits, input bit glitch);
      logic [10:0] bits;
      bits = {stop, par, d, 1'b0};
      lat  = -1;
      for (int b = 0; b < nbits; b++) begin
         ps2_data = bits[b];
         for (int i = 0; i < HALF; i++) begin
            @(posedge clk); #1;
            if (glitch && i == HALF / 2) ps2_clk = 1'b0;
            if (glitch && i == HALF / 2 + FILTER_LEN - 1) ps2_clk = 1'b1;
         end
         ps2_clk = 1'b0;
         for (int i = 1; i <= HALF; i++) begin
            @(posedge clk); #1;
            if (b == 10 && lat < 0 && rx_valid) lat = i;
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic wait_drain(input int max_cycles);
      for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({rx_valid, err_parity, err_frame, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got valid/par/frame/busy=%b required 0000",
                  {rx_valid, err_parity, err_frame, busy});
      end
      checks++;
      if (rx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_rx_data: got %h required 00", rx_data);
      end
   endtask

   task automatic test_basic();
      push_exp(c_EV_VALID, 8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      wait_drain(100);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL basic_pending: got %0d pending required 0", exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
         failures++;
         $display("FAIL basic_latency: got %0d cycles required %0d +/-1", lat, LATENCY);
      end
      checks++;
      if (rx_data !== 8'h1C) begin
         failures++;
         $display("FAIL basic_rx_data: got %h required 1c", rx_data);
      end
   endtask

   task automatic test_back_to_back();
      push_exp(c_EV_VALID, 8'hF0);
      push_exp(c_EV_VALID, 8'h1C);
      send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      wait_drain(100);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_pending: got %0d pending required 0", exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (rx_data !== 8'h1C) begin
         failures++;
         $display("FAIL b2b_rx_data: got %h required 1c", rx_data);
      end
   endtask

   task automatic test_timeout();
      push_exp(c_EV_FRAME, 8'h00);
      send_frame(8'hA5, 1'b1, 1'b1, 5, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL timeout_busy_mid: got %b required 1", busy);
      end
      wait_drain(TIMEOUT + 50);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL timeout_pending: got %0d pending required 0", exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_busy_after: got %b required 0", busy);
      end
      push_exp(c_EV_VALID, 8'hF0);
      send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
      wait_drain(100);
      checks++;
      if (exp_q.size() != 0 || rx_data !== 8'hF0) begin
         failures++;
         $display("FAIL timeout_recover: got pending=%0d rx_data=%h required 0/f0",
                  exp_q.size(), rx_data);
         exp_q.delete();
      end
   endtask

   task automatic test_parity_error();
      push_exp(c_EV_PAR, 8'h00);
      send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
      wait_drain(100);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL parity_pending: got %0d pending required 0", exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (rx_data !== 8'hF0) begin
         failures++;
         $display("FAIL parity_rx_hold: got %h required f0", rx_data);
      end
   endtask

   task automatic test_stop_error();
      push_exp(c_EV_FRAME, 8'h00);
      send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
      wait_drain(100);
      checks++;
      if (exp_q.size() != 0 || rx_data !== 8'hF0) begin
         failures++;
         $display("FAIL stop_error: got pending=%0d rx_data=%h required 0/f0",
                  exp_q.size(), rx_data);
         exp_q.delete();
      end
   endtask

   task automatic test_glitch();
      push_exp(c_EV_VALID, 8'h5A);
      send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b1);
      wait_drain(100);
      checks++;
      if (exp_q.size() != 0 || rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL glitch: got pending=%0d rx_data=%h required 0/5a",
                  exp_q.size(), rx_data);
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'hFF, 1'b1, 1'b1, 4, 1'b0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || rx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid: got busy=%b rx_data=%h required 0/00", busy, rx_data);
      end
      repeat (TIMEOUT + 50) @(posedge clk);
      push_exp(c_EV_VALID, 8'h33);
      send_frame(8'h33, 1'b1, 1'b1, 11, 1'b0);
      wait_drain(100);
      checks++;
      if (exp_q.size() != 0 || rx_data !== 8'h33) begin
         failures++;
         $display("FAIL reset_recover: got pending=%0d rx_data=%h required 0/33",
                  exp_q.size(), rx_data);
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_timeout();
      test_parity_error();
      test_stop_error();
      test_glitch();
      test_reset_mid_frame();
      repeat (20) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
